// File: rtl/fp_mant_mul_pipe_pkg.sv
// Shared constants for the FP multiplier datapath: per-format widths and biases,
// special-case flag positions, and the width of the sideband bundle.
package fp_mant_mul_pipe_pkg;

    localparam int SP_MANT_W = 24;
    localparam int SP_EXP_W  = 8;
    localparam int SP_BIAS   = 127;
    localparam int DP_MANT_W = 53;
    localparam int DP_EXP_W  = 11;
    localparam int DP_BIAS   = 1023;

    localparam int FLAG_NAN  = 2;
    localparam int FLAG_INF  = 1;
    localparam int FLAG_ZERO = 0;
    localparam int NUM_FLAGS = 3;

    // Sideband bundle is packed as {sign, exp[EXP_W:0], flags[2:0], tag}.
    function automatic int sb_width(input int exp_w, input int tag_w);
        return 1 + (exp_w + 1) + NUM_FLAGS + tag_w;
    endfunction

endpackage

// File: rtl/fp_mant_mul_pipe_if.sv
// Valid/ready channel bundle for the mantissa-product stage: operand side,
// result side and the synchronous flush.
interface fp_mant_mul_pipe_if #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8,
    parameter int TAG_W  = 4
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic                  sign_in;
    logic [EXP_W:0]        exp_sum_in;
    logic [MANT_W-1:0]     mant_a_in;
    logic [MANT_W-1:0]     mant_b_in;
    logic [2:0]            flags_in;
    logic [TAG_W-1:0]      tag_in;
    logic                  out_valid;
    logic                  out_ready;
    logic                  sign_out;
    logic [EXP_W:0]        exp_sum_out;
    logic [2*MANT_W-1:0]   mant_prod_out;
    logic [2:0]            flags_out;
    logic [TAG_W-1:0]      tag_out;

    modport master (
        output flush, in_valid, sign_in, exp_sum_in, mant_a_in, mant_b_in,
               flags_in, tag_in, out_ready,
        input  in_ready, out_valid, sign_out, exp_sum_out, mant_prod_out,
               flags_out, tag_out
    );

    modport slave (
        input  flush, in_valid, sign_in, exp_sum_in, mant_a_in, mant_b_in,
               flags_in, tag_in, out_ready,
        output in_ready, out_valid, sign_out, exp_sum_out, mant_prod_out,
               flags_out, tag_out
    );
endinterface

// File: rtl/fp_mant_mul_pipe_mul_pp_stage.sv
// One chunk-multiply-accumulate pipeline stage: adds A * (low CW bits of B),
// weighted by 2^(K*CW), to the incoming partial product.
module mul_pp_stage
    import fp_mant_mul_pipe_pkg::*;
#(
    parameter int MANT_W = 24,
    parameter int CW     = 8,
    parameter int K      = 0,
    parameter int SB_W   = 17
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                flush,
    input  logic                valid_in,
    input  logic [MANT_W-1:0]   a_in,
    input  logic [MANT_W-1:0]   b_in,
    input  logic [2*MANT_W-1:0] acc_in,
    input  logic [SB_W-1:0]     sb_in,
    output logic                valid_out,
    output logic [MANT_W-1:0]   a_out,
    output logic [MANT_W-1:0]   b_out,
    output logic [2*MANT_W-1:0] acc_out,
    output logic [SB_W-1:0]     sb_out
);
    localparam int PW = 2 * MANT_W;

    logic [PW-1:0] partial;
    logic [PW-1:0] acc_base;
    logic [PW-1:0] acc_next;

    // B arrives pre-shifted so the chunk for this stage is always its low CW bits.
    always_comb begin
        partial  = PW'(a_in) * PW'(b_in[CW-1:0]);
        acc_base = (K == 0) ? '0 : acc_in;
        acc_next = acc_base + (partial << (K * CW));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
            acc_out   <= '0;
            sb_out    <= '0;
        end else if (flush) begin
            valid_out <= 1'b0;
        end else if (en) begin
            valid_out <= valid_in;
            a_out     <= a_in;
            b_out     <= b_in >> CW;
            acc_out   <= acc_next;
            sb_out    <= sb_in;
        end
    end

endmodule

// File: rtl/fp_mant_mul_pipe.sv
// Pipelined mantissa product stage: STAGES chunked multiply-accumulate stages
// with exponent re-bias, sideband pass-through, valid/ready and flush.
module fp_mant_mul_pipe
    import fp_mant_mul_pipe_pkg::*;
#(
    parameter int MANT_W = SP_MANT_W,
    parameter int EXP_W  = SP_EXP_W,
    parameter int STAGES = 3,
    parameter int BIAS   = SP_BIAS,
    parameter int TAG_W  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    fp_mant_mul_pipe_if.slave bus
);
    localparam int CW   = MANT_W / STAGES;
    localparam int SB_W = sb_width(EXP_W, TAG_W);
    localparam int PW   = 2 * MANT_W;

    logic              en;
    logic [EXP_W:0]    exp_biased;

    logic              v_w   [STAGES+1];
    logic [MANT_W-1:0] a_w   [STAGES+1];
    logic [MANT_W-1:0] b_w   [STAGES+1];
    logic [PW-1:0]     acc_w [STAGES+1];
    logic [SB_W-1:0]   sb_w  [STAGES+1];

    // The whole pipe moves in lockstep: any free output slot lets every stage advance.
    assign en           = !v_w[STAGES] || bus.out_ready;
    assign bus.in_ready = en && !bus.flush;
    assign exp_biased   = bus.exp_sum_in + (EXP_W+1)'(BIAS);

    assign v_w[0]   = bus.in_valid && bus.in_ready;
    assign a_w[0]   = bus.mant_a_in;
    assign b_w[0]   = bus.mant_b_in;
    assign acc_w[0] = '0;
    assign sb_w[0]  = {bus.sign_in, exp_biased, bus.flags_in, bus.tag_in};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        mul_pp_stage #(
            .MANT_W (MANT_W),
            .CW     (CW),
            .K      (k),
            .SB_W   (SB_W)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .flush     (bus.flush),
            .valid_in  (v_w[k]),
            .a_in      (a_w[k]),
            .b_in      (b_w[k]),
            .acc_in    (acc_w[k]),
            .sb_in     (sb_w[k]),
            .valid_out (v_w[k+1]),
            .a_out     (a_w[k+1]),
            .b_out     (b_w[k+1]),
            .acc_out   (acc_w[k+1]),
            .sb_out    (sb_w[k+1])
        );
    end

    assign bus.out_valid     = v_w[STAGES];
    assign bus.mant_prod_out = acc_w[STAGES];
    assign {bus.sign_out, bus.exp_sum_out, bus.flags_out, bus.tag_out} = sb_w[STAGES];

endmodule

// File: tb/tb_fp_mant_mul_pipe.sv
// Bench for fp_mant_mul_pipe: directed vectors, multi-cycle handshake corners and
// random traffic scored against a queue-based arithmetic reference.
module tb_fp_mant_mul_pipe;
    import fp_mant_mul_pipe_pkg::*;

    localparam int MANT_W = 24;
    localparam int EXP_W  = 8;
    localparam int STAGES = 3;
    localparam int BIAS   = 127;
    localparam int TAG_W  = 4;
    localparam int PW     = 2 * MANT_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_mant_mul_pipe_if #(.MANT_W(MANT_W), .EXP_W(EXP_W), .TAG_W(TAG_W)) bus ();

    fp_mant_mul_pipe #(
        .MANT_W (MANT_W),
        .EXP_W  (EXP_W),
        .STAGES (STAGES),
        .BIAS   (BIAS),
        .TAG_W  (TAG_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [PW-1:0]    prod;
        logic [EXP_W:0]   exp;
        logic             sign;
        logic [2:0]       flags;
        logic [TAG_W-1:0] tag;
    } res_t;

    typedef struct {
        logic [MANT_W-1:0] a;
        logic [MANT_W-1:0] b;
        logic [EXP_W:0]    e;
        logic              s;
        logic [2:0]        f;
        logic [TAG_W-1:0]  t;
        logic [PW-1:0]     prod;
        logic [EXP_W:0]    exp;
    } tv_t;

    res_t exp_q[$];

    function automatic res_t model(input logic s, input logic [EXP_W:0] e,
                                   input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] b,
                                   input logic [2:0] f, input logic [TAG_W-1:0] t);
        res_t r;
        r.prod  = PW'(a) * PW'(b);
        r.exp   = (EXP_W+1)'((e + BIAS) % (1 << (EXP_W + 1)));
        r.sign  = s;
        r.flags = f;
        r.tag   = t;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard: observe each cycle's handshakes at the falling edge.
    res_t        mon_r;
    logic        hold_pend = 1'b0;
    logic [65:0] held;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hold_pend = 1'b0;
        end else begin
            if (hold_pend)
                chk("stall_hold", {bus.out_valid, bus.sign_out, bus.exp_sum_out,
                                   bus.flags_out, bus.tag_out, bus.mant_prod_out}, held);
            hold_pend = 1'b0;
            if (bus.flush) begin
                exp_q.delete();
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", 1, 0);
                    end else begin
                        mon_r = exp_q.pop_front();
                        chk("result", {bus.sign_out, bus.exp_sum_out, bus.flags_out,
                                       bus.tag_out, bus.mant_prod_out},
                            {mon_r.sign, mon_r.exp, mon_r.flags, mon_r.tag, mon_r.prod});
                    end
                end else if (bus.out_valid) begin
                    hold_pend = 1'b1;
                    held = {bus.out_valid, bus.sign_out, bus.exp_sum_out,
                            bus.flags_out, bus.tag_out, bus.mant_prod_out};
                end
                if (bus.in_valid && bus.in_ready)
                    exp_q.push_back(model(bus.sign_in, bus.exp_sum_in, bus.mant_a_in,
                                          bus.mant_b_in, bus.flags_in, bus.tag_in));
            end
        end
    end

    task automatic drive_op(input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] b,
                            input logic [EXP_W:0] e, input logic s,
                            input logic [2:0] f, input logic [TAG_W-1:0] t);
        bus.mant_a_in  = a;
        bus.mant_b_in  = b;
        bus.exp_sum_in = e;
        bus.sign_in    = s;
        bus.flags_in   = f;
        bus.tag_in     = t;
        bus.in_valid   = 1'b1;
    endtask

    task automatic wait_accept();
        bit ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rand();
        drive_op(MANT_W'({$urandom, $urandom}), MANT_W'({$urandom, $urandom}),
                 (EXP_W+1)'($urandom), 1'($urandom), 3'($urandom), TAG_W'($urandom));
        wait_accept();
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.out_valid) done = 1'b1;
        end
        chk("drain_done", done, 1);
        @(posedge clk);
        #1;
    endtask

    tv_t tv[6];

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit found;
        int seen, first, last;

        tv[0] = '{24'hC00000, 24'hC00000, 9'h001, 1'b0, 3'b000, 4'd5, 48'h900000000000, 9'h080};
        tv[1] = '{24'hFFFFFF, 24'hFFFFFF, 9'h000, 1'b1, 3'b001, 4'd9, 48'hFFFFFE000001, 9'h07F};
        tv[2] = '{24'h000001, 24'h000001, 9'h1F0, 1'b0, 3'b100, 4'd3, 48'h000000000001, 9'h06F};
        tv[3] = '{24'h000000, 24'hFFFFFF, 9'h100, 1'b1, 3'b010, 4'd15, 48'h000000000000, 9'h17F};
        tv[4] = '{24'h800000, 24'h800000, 9'h1FF, 1'b0, 3'b111, 4'd0, 48'h400000000000, 9'h07E};
        tv[5] = '{24'hABCDEF, 24'h000001, 9'h0FF, 1'b1, 3'b000, 4'd12, 48'h000000ABCDEF, 9'h17E};

        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drive_op('0, '0, '0, 1'b0, 3'b000, '0);
        bus.in_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_prod", bus.mant_prod_out, 0);
        chk("rst_side", {bus.sign_out, bus.exp_sum_out, bus.flags_out, bus.tag_out}, 0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            drive_op(tv[i].a, tv[i].b, tv[i].e, tv[i].s, tv[i].f, tv[i].t);
            wait_accept();
            lat = 1;
            found = 1'b0;
            while (lat <= 20 && !found) begin
                @(negedge clk);
                if (bus.out_valid) found = 1'b1;
                else begin
                    @(posedge clk);
                    lat++;
                end
            end
            chk("tbl_latency", lat, STAGES);
            chk("tbl_prod", bus.mant_prod_out, tv[i].prod);
            chk("tbl_exp", bus.exp_sum_out, tv[i].exp);
            chk("tbl_side", {bus.sign_out, bus.flags_out, bus.tag_out}, {tv[i].s, tv[i].f, tv[i].t});
            @(posedge clk);
            #1;
        end

        // Back-to-back: ten results on ten consecutive cycles.
        seen = 0; first = -1; last = -1;
        fork
            for (int i = 0; i < 10; i++) send_rand();
            for (int n = 0; n < 30; n++) begin
                @(negedge clk);
                if (bus.out_valid) begin
                    if (first < 0) first = n;
                    last = n;
                    seen++;
                end
            end
        join
        chk("b2b_count", seen, 10);
        chk("b2b_contiguous", last - first + 1, 10);
        drain();

        // Stall with a full pipe.
        bus.out_ready = 1'b0;
        for (int i = 0; i < STAGES; i++) send_rand();
        drive_op(24'h123456, 24'h654321, 9'h042, 1'b1, 3'b010, 4'd7);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_out_valid", bus.out_valid, 1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_accept();
        drain();

        // Flush with ops in flight and a pending input.
        for (int i = 0; i < 3; i++) send_rand();
        drive_op(24'hFEDCBA, 24'h00FF00, 9'h010, 1'b0, 3'b001, 4'd11);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", bus.out_valid, 0);
        chk("flush_in_ready", bus.in_ready, 1);
        for (int i = 0; i < STAGES + 3; i++) begin
            @(negedge clk);
            chk("flush_no_stale", bus.out_valid, 0);
        end
        @(posedge clk);
        #1;

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) send_rand();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_prod", bus.mant_prod_out, 0);
        chk("arst_side", {bus.sign_out, bus.exp_sum_out, bus.flags_out, bus.tag_out}, 0);
        #10 rst_n = 1'b1;
        for (int i = 0; i < STAGES + 2; i++) begin
            @(negedge clk);
            chk("arst_quiet", bus.out_valid, 0);
        end
        @(posedge clk);
        #1;

        // Random traffic with random backpressure and occasional flush.
        for (int n = 0; n < 400; n++) begin
            bus.in_valid   = ($urandom_range(3) != 0);
            bus.mant_a_in  = MANT_W'({$urandom, $urandom});
            bus.mant_b_in  = MANT_W'({$urandom, $urandom});
            bus.exp_sum_in = (EXP_W+1)'($urandom);
            bus.sign_in    = 1'($urandom);
            bus.flags_in   = 3'($urandom);
            bus.tag_in     = TAG_W'($urandom);
            bus.out_ready  = ($urandom_range(3) != 0);
            bus.flush      = ($urandom_range(31) == 0);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
